// File: rtl/flow_rr_arb_mux.sv
// flow_rr_arb_mux
//   Registered NCH-to-1 multiplexer with a valid/ready handshake on every input
//   channel and a round-robin arbiter. The arbiter searches upward from the
//   channel after the last one that transferred, so each requester is served in
//   turn. The output register holds one beat. A new beat is accepted when the
//   register is empty or is being drained in the same cycle, which allows one
//   beat per cycle.
//
//   Optional feature, enabled by the macro FLOW_ARB_LOCK_EN: packet lock.
//   After a beat with in_last=0 is accepted, the arbiter stays on that channel
//   until the beat carrying in_last=1 has been accepted. The round-robin pointer
//   advances only when that final beat is accepted.
//
// Ports
//   clk        clock; all state updates on posedge
//   rst        synchronous reset, active-high
//   in_valid   [NCH]        per-channel request
//   in_data    [NCH*WIDTH]  channel i occupies [i*WIDTH +: WIDTH]
//   in_last    [NCH]        end-of-packet flag per channel (FLOW_ARB_LOCK_EN only)
//   in_ready   [NCH]        one-hot grant, zero when stalled, idle or in reset
//   out_ready  consumer accepts the held beat
//   out_valid  output register holds a beat
//   out_data   [WIDTH]      data of the held beat
//   out_sel    [SELW]       channel index that supplied the held beat
//   out_last   end-of-packet flag of the held beat (FLOW_ARB_LOCK_EN only)
module flow_rr_arb_mux #(
  parameter int NCH   = 32,
  parameter int WIDTH = 20,
  localparam int SELW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
`ifdef FLOW_ARB_LOCK_EN
  input  logic [NCH-1:0]       in_last,
`endif
  output logic [NCH-1:0]       in_ready,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel
`ifdef FLOW_ARB_LOCK_EN
  ,
  output logic                 out_last
`endif
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;
  logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

  logic             accept;
  logic             xfer;
  logic [NCH-1:0]   req;
  logic             gnt_found;
  logic [SELW-1:0]  gnt_idx;

`ifdef FLOW_ARB_LOCK_EN
  typedef enum logic {ARB, LOCKED} state_t;
  state_t          state_q, state_d;
  logic [SELW-1:0] lock_q, lock_d;
  logic            out_last_q, out_last_d;

  // While locked, only the locked channel may compete.
  always_comb begin
    req = in_valid;
    if (state_q == LOCKED) begin
      req = '0;
      req[lock_q] = in_valid[lock_q];
    end
  end
`else
  assign req = in_valid;
`endif

  // Round-robin search: the first requester after rr_ptr_q, wrapping NCH-1 -> 0.
  always_comb begin
    int j;
    logic [SELW-1:0] jj;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    j         = 0;
    jj        = '0;
    for (int k = 1; k <= NCH; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NCH) j = j - NCH;
      jj = j[SELW-1:0];
      if (!gnt_found && req[jj]) begin
        gnt_found = 1'b1;
        gnt_idx   = jj;
      end
    end
  end

  // A slot is free when the register is empty or is being drained this cycle.
  assign accept = !out_valid_q || out_ready;
  assign xfer   = accept && gnt_found && !rst;

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    rr_ptr_d    = rr_ptr_q;
`ifdef FLOW_ARB_LOCK_EN
    state_d    = state_q;
    lock_d     = lock_q;
    out_last_d = out_last_q;
`endif
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(gnt_idx)*WIDTH +: WIDTH];
      out_sel_d   = gnt_idx;
`ifdef FLOW_ARB_LOCK_EN
      out_last_d = in_last[gnt_idx];
      // The pointer moves only when a packet completes.
      if (in_last[gnt_idx]) rr_ptr_d = gnt_idx;
      case (state_q)
        ARB: begin
          if (!in_last[gnt_idx]) begin
            state_d = LOCKED;
            lock_d  = gnt_idx;
          end
        end
        LOCKED: begin
          if (in_last[gnt_idx]) state_d = ARB;
        end
        default: state_d = ARB;
      endcase
`else
      rr_ptr_d = gnt_idx;
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      rr_ptr_q    <= SELW'(NCH - 1);
`ifdef FLOW_ARB_LOCK_EN
      state_q    <= ARB;
      lock_q     <= '0;
      out_last_q <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef FLOW_ARB_LOCK_EN
      state_q    <= state_d;
      lock_q     <= lock_d;
      out_last_q <= out_last_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
`ifdef FLOW_ARB_LOCK_EN
  assign out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_flow_rr_arb_mux.sv
// Testbench for flow_rr_arb_mux (NCH=32, WIDTH=20). A reference model tracks
// the round-robin pointer, the lock state and the output register; expected
// beats are queued when a grant is predicted and compared when the output
// register presents them. Works with and without FLOW_ARB_LOCK_EN.
module tb_flow_rr_arb_mux;
  localparam int NCH   = 32;
  localparam int WIDTH = 20;
  localparam int SELW  = 5;
  localparam int EW    = SELW + WIDTH + 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCH-1:0]       in_valid;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_last;
  logic [NCH-1:0]       in_ready;
  logic                 out_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_sel;
  logic                 out_last;

  always #5 clk = ~clk;

  flow_rr_arb_mux #(.NCH(NCH), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
`ifdef FLOW_ARB_LOCK_EN
    .in_last  (in_last),
`endif
    .in_ready (in_ready),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_sel  (out_sel)
`ifdef FLOW_ARB_LOCK_EN
    ,
    .out_last (out_last)
`endif
  );

`ifndef FLOW_ARB_LOCK_EN
  assign out_last = 1'b0;
`endif

  int ncmp  = 0;
  int nfail = 0;

  logic [EW-1:0] sb[$];
  logic          m_ov   = 1'b0;
  int            m_ptr  = NCH - 1;
  logic          m_lk   = 1'b0;
  int            m_lidx = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge with inputs set for the coming cycle.
  // Checks combinational handshake and held beat, advances the model, and
  // returns one time unit after the next rising edge.
  task automatic cycle();
    logic [NCH-1:0] req;
    logic [NCH-1:0] er;
    logic [EW-1:0]  f;
    logic           acc;
    logic           lst;
    int             g;
    int             idx;
    #1;
    req = in_valid;
`ifdef FLOW_ARB_LOCK_EN
    if (m_lk) begin
      req = '0;
      req[m_lidx] = in_valid[m_lidx];
    end
`endif
    acc = !m_ov || out_ready;
    g = -1;
    for (int k = 1; k <= NCH; k++) begin
      idx = (m_ptr + k) % NCH;
      if (g < 0 && req[idx]) g = idx;
    end
    er = '0;
    if (!rst && acc && g >= 0) er[g] = 1'b1;
    chk("in_ready", in_ready, er);
    chk("out_valid", out_valid, m_ov);
    if (m_ov) begin
      f = (sb.size() > 0) ? sb[0] : 'x;
      chk("out_beat", {out_last, out_sel, out_data}, f);
      if (out_ready && sb.size() > 0) void'(sb.pop_front());
    end
    if (rst) begin
      sb.delete();
      m_ov  = 1'b0;
      m_ptr = NCH - 1;
      m_lk  = 1'b0;
    end else if (er != '0) begin
`ifdef FLOW_ARB_LOCK_EN
      lst = in_last[g];
      if (lst) m_ptr = g;
      if (!m_lk && !lst) begin
        m_lk   = 1'b1;
        m_lidx = g;
      end else if (m_lk && lst) begin
        m_lk = 1'b0;
      end
`else
      lst   = 1'b0;
      m_ptr = g;
`endif
      sb.push_back({lst, SELW'(g), in_data[g*WIDTH +: WIDTH]});
      m_ov = 1'b1;
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    int t1[4] = '{0, 2, 0, 2};
    rst       = 1'b1;
    in_valid  = '0;
    in_last   = '1;
    out_ready = 1'b1;
    for (int i = 0; i < NCH; i++) in_data[i*WIDTH +: WIDTH] = WIDTH'(i);
    @(posedge clk);
    #1;
    cycle();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, '0);
    chk("rst_sel", out_sel, '0);
    rst = 1'b0;

    // Two requesters alternate from channel 0.
    in_valid = 32'h0000_0005;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t1_sel", out_sel, t1[i]);
      chk("t1_valid", out_valid, 1'b1);
    end
    in_valid = '0;
    cycle();

    // All channels: one beat per cycle, 0..31 then wrap.
    do_reset();
    in_valid = '1;
    for (int i = 0; i < NCH + 1; i++) begin
      cycle();
      chk("t2_sel", out_sel, i % NCH);
      chk("t2_data", out_data, i % NCH);
    end
    in_valid = '0;
    cycle();

    // Stall holds the beat; release consumes exactly one.
    in_valid = 32'h1 << 5;
    in_data[5*WIDTH +: WIDTH] = 20'hABCDE;
    cycle();
    chk("t3_load", out_sel, 5);
    out_ready = 1'b0;
    in_valid  = '1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t3_sel", out_sel, 5);
      chk("t3_data", out_data, 20'hABCDE);
      chk("t3_ready", in_ready, '0);
    end
    in_valid  = '0;
    out_ready = 1'b1;
    cycle();
    chk("t3_drained", out_valid, 1'b0);
    in_data[5*WIDTH +: WIDTH] = 20'd5;

    // Pointer at 3: ch 4 before ch 3, pointer left at 3.
    in_valid = 32'h1 << 3;
    cycle();
    in_valid = (32'h1 << 3) | (32'h1 << 4);
    cycle();
    chk("t4_first", out_sel, 4);
    cycle();
    chk("t4_second", out_sel, 3);
    in_valid = (32'h1 << 0) | (32'h1 << 4);
    cycle();
    chk("t4_ptr", out_sel, 4);
    in_valid = '0;
    cycle();

    // Reset with a beat held.
    in_valid  = 32'h1 << 7;
    out_ready = 1'b0;
    cycle();
    chk("t5_held", out_valid, 1'b1);
    rst = 1'b1;
    cycle();
    chk("t5_cleared", out_valid, 1'b0);
    rst       = 1'b0;
    out_ready = 1'b1;
    in_valid  = (32'h1 << 6) | (32'h1 << 9);
    cycle();
    chk("t5_lowest", out_sel, 6);
    in_valid = '0;
    cycle();

`ifdef FLOW_ARB_LOCK_EN
    // Three-beat packet on ch 1 is not interrupted by ch 2.
    do_reset();
    in_valid = (32'h1 << 1) | (32'h1 << 2);
    in_last  = '0;
    cycle();
    chk("t6_b1", {out_last, out_sel}, {1'b0, 5'd1});
    cycle();
    chk("t6_b2", {out_last, out_sel}, {1'b0, 5'd1});
    in_last[1] = 1'b1;
    cycle();
    chk("t6_b3", {out_last, out_sel}, {1'b1, 5'd1});
    cycle();
    chk("t6_ch2", {out_last, out_sel}, {1'b0, 5'd2});
    in_last  = '1;
    in_valid = '0;
    cycle();
`endif

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      in_valid  = $urandom & $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef FLOW_ARB_LOCK_EN
      in_last = $urandom | $urandom;
`endif
      for (int c = 0; c < NCH; c++) in_data[c*WIDTH +: WIDTH] = WIDTH'($urandom);
      cycle();
    end
    in_valid  = '0;
    in_last   = '1;
    out_ready = 1'b1;
    cycle();
    cycle();
    chk("final_empty", out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
